// File: rtl/arm_dp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_dp_pkg
// Description : Shared constants for the ARM7 data-processing issue block:
//               opcodes, condition codes, controller states, instruction
//               field positions and opcode-class helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_dp_pkg;

  // Data-processing opcodes, instr[24:21]
  localparam logic [3:0] c_op_and = 4'd0;
  localparam logic [3:0] c_op_eor = 4'd1;
  localparam logic [3:0] c_op_sub = 4'd2;
  localparam logic [3:0] c_op_rsb = 4'd3;
  localparam logic [3:0] c_op_add = 4'd4;
  localparam logic [3:0] c_op_adc = 4'd5;
  localparam logic [3:0] c_op_sbc = 4'd6;
  localparam logic [3:0] c_op_rsc = 4'd7;
  localparam logic [3:0] c_op_tst = 4'd8;
  localparam logic [3:0] c_op_teq = 4'd9;
  localparam logic [3:0] c_op_cmp = 4'd10;
  localparam logic [3:0] c_op_cmn = 4'd11;
  localparam logic [3:0] c_op_orr = 4'd12;
  localparam logic [3:0] c_op_mov = 4'd13;
  localparam logic [3:0] c_op_bic = 4'd14;
  localparam logic [3:0] c_op_mvn = 4'd15;

  // Condition codes, instr[31:28]
  localparam logic [3:0] c_cond_eq = 4'd0;
  localparam logic [3:0] c_cond_ne = 4'd1;
  localparam logic [3:0] c_cond_cs = 4'd2;
  localparam logic [3:0] c_cond_cc = 4'd3;
  localparam logic [3:0] c_cond_mi = 4'd4;
  localparam logic [3:0] c_cond_pl = 4'd5;
  localparam logic [3:0] c_cond_vs = 4'd6;
  localparam logic [3:0] c_cond_vc = 4'd7;
  localparam logic [3:0] c_cond_hi = 4'd8;
  localparam logic [3:0] c_cond_ls = 4'd9;
  localparam logic [3:0] c_cond_ge = 4'd10;
  localparam logic [3:0] c_cond_lt = 4'd11;
  localparam logic [3:0] c_cond_gt = 4'd12;
  localparam logic [3:0] c_cond_le = 4'd13;
  localparam logic [3:0] c_cond_al = 4'd14;
  localparam logic [3:0] c_cond_nv = 4'd15;

  // Controller states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // Instruction field bit positions
  localparam int c_fld_cond_hi = 31;
  localparam int c_fld_cond_lo = 28;
  localparam int c_fld_cls_hi  = 27;
  localparam int c_fld_cls_lo  = 26;
  localparam int c_fld_i       = 25;
  localparam int c_fld_op_hi   = 24;
  localparam int c_fld_op_lo   = 21;
  localparam int c_fld_s       = 20;
  localparam int c_fld_rn_hi   = 19;
  localparam int c_fld_rn_lo   = 16;
  localparam int c_fld_rd_hi   = 15;
  localparam int c_fld_rd_lo   = 12;
  localparam int c_fld_rot_hi  = 11;
  localparam int c_fld_rot_lo  = 8;
  localparam int c_fld_imm_hi  = 7;
  localparam int c_fld_imm_lo  = 0;

  // Compare-class opcodes: flags only, never written back
  function automatic logic is_test_op(input logic [3:0] op);
    return (op == c_op_tst) || (op == c_op_teq) ||
           (op == c_op_cmp) || (op == c_op_cmn);
  endfunction

  // Opcodes whose C/V come from the adder rather than the shifter
  function automatic logic is_arith_op(input logic [3:0] op);
    return (op == c_op_sub) || (op == c_op_rsb) || (op == c_op_add) ||
           (op == c_op_adc) || (op == c_op_sbc) || (op == c_op_rsc) ||
           (op == c_op_cmp) || (op == c_op_cmn);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dp_issue_ctrl_cond_check.sv
`default_nettype none
// ============================================================================
// Module      : cond_check
// Description : Combinational ARM condition-field evaluator.
//   i_cond  [3:0]  condition field of the instruction
//   i_nzcv  [3:0]  current flags {N,Z,C,V}
//   o_pass         1 when the instruction should execute (NV never passes)
// Revision    : 1.0 - initial release
// ============================================================================
module cond_check
  import arm_dp_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_nzcv,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = i_nzcv;

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      c_cond_eq: o_pass = w_z;
      c_cond_ne: o_pass = !w_z;
      c_cond_cs: o_pass = w_c;
      c_cond_cc: o_pass = !w_c;
      c_cond_mi: o_pass = w_n;
      c_cond_pl: o_pass = !w_n;
      c_cond_vs: o_pass = w_v;
      c_cond_vc: o_pass = !w_v;
      c_cond_hi: o_pass = w_c && !w_z;
      c_cond_ls: o_pass = !w_c || w_z;
      c_cond_ge: o_pass = (w_n == w_v);
      c_cond_lt: o_pass = (w_n != w_v);
      c_cond_gt: o_pass = !w_z && (w_n == w_v);
      c_cond_le: o_pass = w_z || (w_n != w_v);
      c_cond_al: o_pass = 1'b1;
      default:   o_pass = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dp_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dp_issue_ctrl
// Description : Issue/control side of the ARM7 data-processing ALU. Accepts a
//               DP instruction with Rn/Rm values, checks its condition against
//               the owned CPSR flags, drives the ALU, folds the ALU flags back
//               into NZCV and hands the result to the register file.
//   clk, reset_n                      clock, async active-low reset
//   in_valid/in_ready, instr,
//   rn_val, rm_val                    instruction + operand handshake
//   flush                             synchronous kill of in-flight work
//   alu_control, operand_a/_b,
//   alu_carry_in                      registered ALU inputs
//   alu_result, alu_nzcv              ALU outputs, sampled in EXEC
//   wb_valid/wb_ready, wb_rd, wb_data register-file write-back handshake
//   flags_wr_en, flags_wr_data        external (MSR) flag load
//   nzcv                              current CPSR flags
//   illegal                           pulse for an accepted non-DP word
// Revision    : 1.0 - initial release
// ============================================================================
module dp_issue_ctrl
  import arm_dp_pkg::*;
#(
  parameter int         DATA_W      = 32,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rn_val,
  input  logic [DATA_W-1:0] rm_val,
  input  logic              flush,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic              alu_carry_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_nzcv,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [3:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic              flags_wr_en,
  input  logic [3:0]        flags_wr_data,
  output logic [3:0]        nzcv,
  output logic              illegal
);

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_nzcv, w_nzcv_nxt;
  logic [3:0]        r_op;
  logic [DATA_W-1:0] r_opa, r_opb, r_wb_data;
  logic              r_cin, r_s, r_sh_c, r_wb_valid, r_illegal;
  logic [3:0]        r_rd, r_wb_rd;

  logic              w_pass, w_accept, w_is_dp, w_issue, w_sh_c;
  logic [4:0]        w_rot;
  logic [DATA_W-1:0] w_imm, w_rotated, w_op2;
  logic              w_unused_rn_field;

  // Rn arrives as a value; the register index itself is not needed here.
  assign w_unused_rn_field = ^instr[c_fld_rn_hi:c_fld_rn_lo];

  cond_check u_cond_check (
    .i_cond (instr[c_fld_cond_hi:c_fld_cond_lo]),
    .i_nzcv (r_nzcv),
    .o_pass (w_pass)
  );

  // flush takes priority over a same-cycle accept in IDLE.
  assign w_accept = (r_state == ST_IDLE) && in_valid && !flush;
  assign w_is_dp  = (instr[c_fld_cls_hi:c_fld_cls_lo] == 2'b00);
  assign w_issue  = w_accept && w_is_dp && w_pass;

  // Immediate operand 2: imm8 rotated right by twice the rotate field. A
  // shift by the full width yields zero, so rot==0 collapses to plain imm8.
  assign w_rot     = {instr[c_fld_rot_hi:c_fld_rot_lo], 1'b0};
  assign w_imm     = {{(DATA_W-8){1'b0}}, instr[c_fld_imm_hi:c_fld_imm_lo]};
  assign w_rotated = (w_imm >> w_rot) | (w_imm << (6'd32 - {1'b0, w_rot}));
  assign w_op2     = instr[c_fld_i] ? w_rotated : rm_val;
  assign w_sh_c    = (instr[c_fld_i] && (w_rot != 5'd0)) ? w_rotated[DATA_W-1]
                                                        : r_nzcv[1];

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_issue) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = is_test_op(r_op) ? ST_IDLE : ST_WB;
      ST_WB:   if (wb_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end

  // ---------------- output logic ----------------
  always_comb begin
    in_ready = (r_state == ST_IDLE);
  end

  // Flag update: logical ops keep V and take C from the shifter; an external
  // write overrides any same-cycle EXEC update, and flush suppresses EXEC.
  always_comb begin
    w_nzcv_nxt = r_nzcv;
    if ((r_state == ST_EXEC) && !flush && r_s) begin
      if (is_arith_op(r_op)) w_nzcv_nxt = alu_nzcv;
      else                   w_nzcv_nxt = {alu_nzcv[3:2], r_sh_c, r_nzcv[0]};
    end
    if (flags_wr_en) w_nzcv_nxt = flags_wr_data;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_nzcv     <= RESET_FLAGS;
      r_op       <= 4'd0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_cin      <= 1'b0;
      r_s        <= 1'b0;
      r_sh_c     <= 1'b0;
      r_rd       <= 4'd0;
      r_wb_rd    <= 4'd0;
      r_wb_data  <= '0;
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_nzcv    <= w_nzcv_nxt;
      r_illegal <= w_accept && !w_is_dp;
      if (w_issue) begin
        r_op   <= instr[c_fld_op_hi:c_fld_op_lo];
        r_opa  <= rn_val;
        r_opb  <= w_op2;
        r_cin  <= r_nzcv[1];
        r_s    <= instr[c_fld_s];
        r_sh_c <= w_sh_c;
        r_rd   <= instr[c_fld_rd_hi:c_fld_rd_lo];
      end
      if (flush) begin
        r_wb_valid <= 1'b0;
      end else if ((r_state == ST_EXEC) && !is_test_op(r_op)) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_data  <= alu_result;
      end else if (r_wb_valid && wb_ready) begin
        r_wb_valid <= 1'b0;
      end
    end
  end

  assign alu_control  = r_op;
  assign operand_a    = r_opa;
  assign operand_b    = r_opb;
  assign alu_carry_in = r_cin;
  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign nzcv         = r_nzcv;
  assign illegal      = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_dp_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_issue_ctrl
// Description : Scoreboard bench for dp_issue_ctrl. The bench plays the ALU,
//               keeps an instruction-level model of CPSR and expected
//               write-backs, and a separate monitor checks each write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_issue_ctrl;

  localparam logic [3:0] c_rst_flags = 4'b0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] instr, rn_val, rm_val;
  logic        flush;
  logic [3:0]  alu_control;
  logic [31:0] operand_a, operand_b;
  logic        alu_carry_in;
  logic [31:0] alu_result;
  logic [3:0]  alu_nzcv;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flags_wr_en;
  logic [3:0]  flags_wr_data;
  logic [3:0]  nzcv;
  logic        illegal;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wb_mode = 0;   // 0 random, 1 forced low, 2 forced high
  logic [3:0]  m_nzcv;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  dp_issue_ctrl #(.DATA_W(32), .RESET_FLAGS(c_rst_flags)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rn_val(rn_val), .rm_val(rm_val), .flush(flush),
    .alu_control(alu_control), .operand_a(operand_a), .operand_b(operand_b),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_nzcv(alu_nzcv),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .flags_wr_en(flags_wr_en), .flags_wr_data(flags_wr_data), .nzcv(nzcv),
    .illegal(illegal)
  );

  // Behavioural ALU: {nzcv, result}. Logical ops report C=V=1 on purpose so
  // the controller is seen to ignore them.
  function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    logic [31:0] r, x, y;
    logic [32:0] sum;
    logic        ci, v, lg;
    x = a; y = b; ci = 1'b0; lg = 1'b1; r = 32'd0;
    case (op)
      4'd0, 4'd8:  r = a & b;
      4'd1, 4'd9:  r = a ^ b;
      4'd12:       r = a | b;
      4'd13:       r = b;
      4'd14:       r = a & ~b;
      4'd15:       r = ~b;
      4'd2, 4'd10: begin lg = 1'b0; y = ~b; ci = 1'b1; end
      4'd3:        begin lg = 1'b0; x = b; y = ~a; ci = 1'b1; end
      4'd4, 4'd11: lg = 1'b0;
      4'd5:        begin lg = 1'b0; ci = cin; end
      4'd6:        begin lg = 1'b0; y = ~b; ci = cin; end
      default:     begin lg = 1'b0; x = b; y = ~a; ci = cin; end
    endcase
    if (lg) return {r[31], (r == 32'd0), 2'b11, r};
    sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    r   = sum[31:0];
    v   = (x[31] == y[31]) && (r[31] != x[31]);
    return {r[31], (r == 32'd0), sum[32], v, r};
  endfunction

  assign {alu_nzcv, alu_result} = alu_f(alu_control, operand_a, operand_b, alu_carry_in);

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0: return z;          4'd1: return !z;
      4'd2: return cf;         4'd3: return !cf;
      4'd4: return n;          4'd5: return !n;
      4'd6: return v;          4'd7: return !v;
      4'd8: return cf && !z;   4'd9: return !cf || z;
      4'd10: return n == v;    4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] cond, input logic i, input logic [3:0] op,
                                     input logic s, input logic [3:0] rd, input logic [11:0] op2);
    return {cond, 2'b00, i, op, s, 4'h0, rd, op2};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_wb(input int m);
    wb_mode = m;
    if (m != 0) wb_ready = (m == 2);
  endtask

  // Returns at negedge+2 once the controller is idle again.
  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #2;
      if (in_ready) return;
    end
    chk("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_wb();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #2;
      if (wb_valid) return;
    end
    chk("wb_timeout", 32'(wb_valid), 32'd1);
  endtask

  task automatic msr(input logic [3:0] d);
    wait_idle();
    flags_wr_en = 1'b1; flags_wr_data = d;
    @(negedge clk);
    flags_wr_en = 1'b0;
    m_nzcv = d;
    #2 chk("msr_nzcv", 32'(nzcv), 32'(d));
  endtask

  // mode: 0 plain, 1 flush in EXEC, 2 flag write in EXEC, 3 reset during WB.
  // hold: cycles to keep wb_ready low after write-back appears.
  task automatic issue(input logic [31:0] ins, input logic [31:0] rn, input logic [31:0] rm,
                       input int mode, input logic [3:0] fdata, input int hold);
    logic        legal, pass, shc, tst, arith;
    logic [31:0] op2, res;
    logic [3:0]  op, anz, newf;
    logic [35:0] ar;
    longint unsigned w;
    int          rot;
    wait_idle();
    if (hold > 0 || mode == 3) set_wb(1);
    in_valid = 1'b1; instr = ins; rn_val = rn; rm_val = rm;

    legal = (ins[27:26] == 2'b00);
    pass  = legal && cond_ok(ins[31:28], m_nzcv);
    op    = ins[24:21];
    rot   = 2 * int'(ins[11:8]);
    if (!ins[25])      begin op2 = rm;              shc = m_nzcv[1]; end
    else if (rot == 0) begin op2 = {24'd0, ins[7:0]}; shc = m_nzcv[1]; end
    else begin
      w   = 64'(ins[7:0]);
      op2 = 32'((w >> rot) | (w << (32 - rot)));
      shc = op2[31];
    end
    ar    = alu_f(op, rn, op2, m_nzcv[1]);
    anz   = ar[35:32];
    res   = ar[31:0];
    tst   = (op >= 4'd8) && (op <= 4'd11);
    arith = ((op >= 4'd2) && (op <= 4'd7)) || (op == 4'd10) || (op == 4'd11);

    @(negedge clk);
    in_valid = 1'b0;
    if (mode == 1) flush = 1'b1;
    if (mode == 2) begin flags_wr_en = 1'b1; flags_wr_data = fdata; end
    #1;
    chk("illegal", 32'(illegal), 32'(!legal));
    chk("in_ready_c1", 32'(in_ready), 32'(!pass));
    if (pass) begin
      chk("alu_control", 32'(alu_control), 32'(op));
      chk("operand_a", operand_a, rn);
      chk("operand_b", operand_b, op2);
      chk("alu_carry_in", 32'(alu_carry_in), 32'(m_nzcv[1]));
    end
    newf = m_nzcv;
    if (pass && ins[20] && mode != 1)
      newf = arith ? anz : {anz[3:2], shc, m_nzcv[0]};
    if (mode == 2) newf = fdata;
    if (pass && !tst && mode != 1) exp_q.push_back({ins[15:12], res});
    m_nzcv = newf;

    @(negedge clk);
    flush = 1'b0; flags_wr_en = 1'b0;
    if (!legal) begin #1 chk("illegal_pulse", 32'(illegal), 32'd0); end

    if (mode == 3 && pass && !tst) begin
      wait_wb();
      #1 reset_n = 1'b0;
      #1;
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_nzcv", 32'(nzcv), 32'(c_rst_flags));
      exp_q.delete();
      m_nzcv = c_rst_flags;
      @(negedge clk); #2 reset_n = 1'b1;
      set_wb(0);
    end else if (hold > 0 && pass && !tst) begin
      wait_wb();
      repeat (hold) @(negedge clk);
      set_wb(2);
    end
    wait_idle();
    set_wb(0);
    chk("nzcv", 32'(nzcv), 32'(m_nzcv));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // wb_ready driver
  initial begin
    wb_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_mode == 0) wb_ready = ($urandom_range(0, 3) != 0);
      else              wb_ready = (wb_mode == 2);
    end
  end

  // Write-back monitor
  initial begin
    logic        pv, pacc;
    logic [3:0]  prd;
    logic [31:0] pdata;
    logic [35:0] e;
    pv = 1'b0; pacc = 1'b0; prd = 4'd0; pdata = 32'd0;
    forever begin
      @(negedge clk); #1;
      if (!reset_n) begin
        pv = 1'b0; pacc = 1'b0;
      end else begin
        if (pv && !pacc) begin
          chk("wb_hold_valid", 32'(wb_valid), 32'd1);
          chk("wb_hold_rd", 32'(wb_rd), 32'(prd));
          chk("wb_hold_data", wb_data, pdata);
        end
        if (pacc) chk("wb_drop", 32'(wb_valid), 32'd0);
        if (wb_valid) begin
          chk("wb_in_ready", 32'(in_ready), 32'd0);
          if (wb_ready) begin
            if (exp_q.size() == 0) begin
              chk("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("wb_rd", 32'(wb_rd), 32'(e[35:32]));
              chk("wb_data", wb_data, e[31:0]);
            end
          end
        end
        pv = wb_valid; pacc = wb_valid && wb_ready; prd = wb_rd; pdata = wb_data;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [31:0] ins;
    int          r, mode;
    reset_n = 1'b0; in_valid = 1'b0; instr = 32'd0; rn_val = 32'd0; rm_val = 32'd0;
    flush = 1'b0; flags_wr_en = 1'b0; flags_wr_data = 4'd0;
    m_nzcv = c_rst_flags;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wb_valid0", 32'(wb_valid), 32'd0);
    chk("rst_nzcv0", 32'(nzcv), 32'(c_rst_flags));
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_alu_control", 32'(alu_control), 32'd0);
    chk("rst_operand_a", operand_a, 32'd0);
    chk("rst_operand_b", operand_b, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    #1 reset_n = 1'b1;

    // ADDS imm 1 to 0x7FFFFFFF -> 0x80000000, NZCV 1001
    issue(mk(4'he, 1'b1, 4'd4, 1'b1, 4'd2, 12'h001), 32'h7FFF_FFFF, 32'd0, 0, 4'd0, 0);
    chk("tp_add_nzcv", 32'(nzcv), 32'h9);
    // CMP 5,#5 -> 0110, then MOVNE is skipped
    issue(mk(4'he, 1'b1, 4'd10, 1'b1, 4'd0, 12'h005), 32'd5, 32'd0, 0, 4'd0, 0);
    chk("tp_cmp_nzcv", 32'(nzcv), 32'h6);
    issue(mk(4'h1, 1'b1, 4'd13, 1'b0, 4'd1, 12'h0AA), 32'd0, 32'd0, 0, 4'd0, 0);
    // MOVS #0xFF ror 8 with V=1 -> 1011
    msr(4'b0001);
    issue(mk(4'he, 1'b1, 4'd13, 1'b1, 4'd3, 12'h4FF), 32'd0, 32'd0, 0, 4'd0, 0);
    chk("tp_movs_nzcv", 32'(nzcv), 32'hB);
    // Backpressure for 5 cycles
    issue(mk(4'he, 1'b0, 4'd4, 1'b0, 4'd4, 12'h000), 32'h1234, 32'h1111, 0, 4'd0, 5);
    // Flush in EXEC of ADDS; flag write in EXEC of ADDS
    issue(mk(4'he, 1'b0, 4'd4, 1'b1, 4'd5, 12'h000), 32'hFFFF_FFFF, 32'd1, 1, 4'd0, 0);
    chk("tp_flush_nzcv", 32'(nzcv), 32'hB);
    issue(mk(4'he, 1'b0, 4'd4, 1'b1, 4'd6, 12'h000), 32'hFFFF_FFFF, 32'd1, 2, 4'b0100, 0);
    chk("tp_msr_exec_nzcv", 32'(nzcv), 32'h4);
    // LDR word is illegal; then reset during WB
    issue(32'hE590_1000, 32'd0, 32'd0, 0, 4'd0, 0);
    issue(mk(4'he, 1'b0, 4'd13, 1'b1, 4'd7, 12'h000), 32'd0, 32'h8000_0000, 3, 4'd0, 0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 19) == 0) msr(4'($urandom));
      ins = mk(4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
               4'($urandom), 12'($urandom));
      if ($urandom_range(0, 11) == 0) ins[27:26] = 2'($urandom_range(1, 3));
      r = $urandom_range(0, 99);
      mode = (r < 5) ? 1 : (r < 10) ? 2 : 0;
      issue(ins, $urandom, $urandom, mode, 4'($urandom), 0);
    end

    wait_idle();
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
